// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit and its tracking FIFO.
package load_store_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef struct packed {
    logic             is_store;
    logic [TAG_W-1:0] tag;
  } track_entry_t;

endpackage

// File: rtl/load_store_unit_tag_fifo.sv
// In-order tracking FIFO remembering {is_store, tag} for every request issued
// to the cache; the count doubles as the outstanding-request counter.
module tag_fifo
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  track_entry_t             entry_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output track_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  track_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  // DEPTH is a power of two, so plain pointer increments wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: forwards pipeline ops to the cache, tracks them in order,
// and returns load results through a one-entry response register.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_store,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   cache_valid_in,
  input  logic                   cache_ready_in,
  output logic [ADDR_W-1:0]      cache_addr_in,
  output logic                   cache_op_in,
  output logic [DATA_W-1:0]      cache_write_data_in,
  input  logic                   cache_valid_out,
  output logic                   cache_ready_out,
  input  logic [DATA_W-1:0]      cache_data_out,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_data,
  output logic [TAG_W-1:0]       resp_tag,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err
);

  logic         fifo_full, fifo_empty;
  logic         push, pop;
  track_entry_t push_entry, head;

  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q,  resp_data_d;
  logic [TAG_W-1:0]  resp_tag_q,   resp_tag_d;
  logic              err_q,        err_d;

  // Full comes from the registered count only, so a response retiring this
  // cycle frees a slot no earlier than the next cycle.
  assign cache_valid_in      = ~rst & req_valid & ~fifo_full;
  assign req_ready           = ~rst & cache_ready_in & ~fifo_full;
  assign cache_addr_in       = req_addr;
  assign cache_op_in         = req_is_store;
  assign cache_write_data_in = req_wdata;

  assign push       = cache_valid_in & cache_ready_in;
  assign push_entry = '{is_store: req_is_store, tag: req_tag};

  // Store responses never need the result register, so they drain regardless.
  assign cache_ready_out = ~rst & ~fifo_empty &
                           ((head.is_store == OP_STORE) | ~resp_valid_q | resp_ready);
  assign pop = cache_valid_out & cache_ready_out;

  tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head),
    .count_o (outstanding)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    err_d        = err_q;
    if (pop && head.is_store == OP_LOAD) begin
      resp_valid_d = 1'b1;
      resp_data_d  = cache_data_out;
      resp_tag_d   = head.tag;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
    if (cache_valid_out && fifo_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      err_q        <= err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a queue-based model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_load_store_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_tag = '0;
  logic        cache_valid_in;
  logic        cache_ready_in = 1'b0;
  logic [31:0] cache_addr_in;
  logic        cache_op_in;
  logic [31:0] cache_write_data_in;
  logic        cache_valid_out = 1'b0;
  logic        cache_ready_out;
  logic [31:0] cache_data_out = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic [2:0]  outstanding;
  logic        err;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_is_store        (req_is_store),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_tag             (req_tag),
    .cache_valid_in      (cache_valid_in),
    .cache_ready_in      (cache_ready_in),
    .cache_addr_in       (cache_addr_in),
    .cache_op_in         (cache_op_in),
    .cache_write_data_in (cache_write_data_in),
    .cache_valid_out     (cache_valid_out),
    .cache_ready_out     (cache_ready_out),
    .cache_data_out      (cache_data_out),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_data           (resp_data),
    .resp_tag            (resp_tag),
    .outstanding         (outstanding),
    .err                 (err)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a queue of requests awaiting their cache response, the
  // pipeline-facing result register, the sticky error, and a log of every
  // load tag the pipeline actually consumed.
  typedef struct {
    bit         isStore;
    logic [4:0] tag;
  } pend_t;

  pend_t       pend[$];
  bit          mRespValid = 1'b0;
  logic [31:0] mRespData  = '0;
  logic [4:0]  mRespTag   = '0;
  bit          mErr       = 1'b0;
  logic [4:0]  deliveredTags[$];

  function automatic bit modelCacheReady();
    if (rst || pend.size() == 0) return 1'b0;
    return pend[0].isStore || !mRespValid || resp_ready;
  endfunction

  // Model update at every rising edge (or immediately on reset assertion).
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pend.delete();
      mRespValid = 1'b0;
      mRespData  = '0;
      mRespTag   = '0;
      mErr       = 1'b0;
    end else begin
      bit    issue;
      bit    respTaken;
      bit    reload;
      pend_t head;
      pend_t e;
      issue     = req_valid && cache_ready_in && (pend.size() < DEPTH);
      respTaken = cache_valid_out && modelCacheReady();
      if (cache_valid_out && pend.size() == 0) mErr = 1'b1;
      if (mRespValid && resp_ready) deliveredTags.push_back(mRespTag);
      reload = 1'b0;
      if (respTaken) begin
        head = pend.pop_front();
        if (!head.isStore) begin
          reload    = 1'b1;
          mRespData = cache_data_out;
          mRespTag  = head.tag;
        end
      end
      if (reload) mRespValid = 1'b1;
      else if (resp_ready) mRespValid = 1'b0;
      if (issue) begin
        e.isStore = req_is_store;
        e.tag     = req_tag;
        pend.push_back(e);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    begin
      bit full;
      full = (pend.size() >= DEPTH);
      checkOutput("req_ready", 32'(req_ready), 32'(!rst && cache_ready_in && !full));
      checkOutput("cache_valid_in", 32'(cache_valid_in), 32'(!rst && req_valid && !full));
      checkOutput("cache_ready_out", 32'(cache_ready_out), 32'(modelCacheReady()));
      checkOutput("outstanding", 32'(outstanding), 32'(pend.size()));
      checkOutput("resp_valid", 32'(resp_valid), 32'(mRespValid));
      checkOutput("err", 32'(err), 32'(mErr));
      if (mRespValid) begin
        checkOutput("resp_data", resp_data, mRespData);
        checkOutput("resp_tag", 32'(resp_tag), 32'(mRespTag));
      end
      if (!rst && req_valid && !full) begin
        checkOutput("cache_addr_in", cache_addr_in, req_addr);
        checkOutput("cache_op_in", 32'(cache_op_in), 32'(req_is_store));
        checkOutput("cache_write_data_in", cache_write_data_in, req_wdata);
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until the unit takes it.
  task automatic applyStimulus(input logic isStore, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] tag);
    bit done;
    done           = 1'b0;
    req_valid      = 1'b1;
    req_is_store   = isStore;
    req_addr       = addr;
    req_wdata      = wdata;
    req_tag        = tag;
    cache_ready_in = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!done) checkOutput("issue_timeout", 32'd0, 32'd1);
  endtask

  // Act as the cache: offer one response and hold it until accepted.
  task automatic cacheRespond(input logic [31:0] data);
    bit done;
    done            = 1'b0;
    cache_valid_out = 1'b1;
    cache_data_out  = data;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cache_ready_out) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    cache_valid_out = 1'b0;
    if (!done) checkOutput("cache_resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;

    // Reset state, with the cache willing so req_ready would otherwise be 1.
    cache_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_resp_tag", 32'(resp_tag), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    stepCycle();

    // Single load, answered on the following cycle.
    resp_ready = 1'b1;
    applyStimulus(1'b0, 32'h100, 32'h0, 5'd3);
    checkOutput("t1_outstanding_1", 32'(outstanding), 32'd1);
    cacheRespond(32'hDEADBEEF);
    checkOutput("t1_resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("t1_resp_data", resp_data, 32'hDEADBEEF);
    checkOutput("t1_resp_tag", 32'(resp_tag), 32'd3);
    checkOutput("t1_outstanding_0", 32'(outstanding), 32'd0);
    stepCycle();
    checkOutput("t1_resp_consumed", 32'(resp_valid), 32'd0);

    // Store: pass-through fields, and its response must not produce a result.
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_addr     = 32'h200;
    req_wdata    = 32'h12345678;
    req_tag      = 5'd0;
    #1;
    checkOutput("t2_cache_op", 32'(cache_op_in), 32'd1);
    checkOutput("t2_cache_wdata", cache_write_data_in, 32'h12345678);
    checkOutput("t2_cache_addr", cache_addr_in, 32'h200);
    stepCycle();
    req_valid = 1'b0;
    checkOutput("t2_outstanding_1", 32'(outstanding), 32'd1);
    cacheRespond(32'h55AA55AA);
    checkOutput("t2_no_resp", 32'(resp_valid), 32'd0);
    checkOutput("t2_outstanding_0", 32'(outstanding), 32'd0);
    stepCycle();
    checkOutput("t2_no_resp_later", 32'(resp_valid), 32'd0);

    // Fill all four slots, then show a same-cycle pop does not unblock issue.
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_tag  = 5'(10 + i);
      req_addr = 32'h300 + 32'(4 * i);
      stepCycle();
    end
    req_tag = 5'd20;
    #1;
    checkOutput("t3_outstanding_full", 32'(outstanding), 32'd4);
    checkOutput("t3_req_ready_full", 32'(req_ready), 32'd0);
    checkOutput("t3_cvi_full", 32'(cache_valid_in), 32'd0);
    cache_valid_out = 1'b1;
    cache_data_out  = 32'h1000;
    #1;
    checkOutput("t3_req_ready_same_cycle", 32'(req_ready), 32'd0);
    stepCycle();
    cache_valid_out = 1'b0;
    checkOutput("t3_req_ready_next", 32'(req_ready), 32'd1);
    checkOutput("t3_outstanding_3", 32'(outstanding), 32'd3);
    checkOutput("t3_first_tag", 32'(resp_tag), 32'd10);
    req_valid = 1'b0;
    for (int k = 1; k < 4; k++) cacheRespond(32'h1000 + 32'(k));
    checkOutput("t3_last_tag", 32'(resp_tag), 32'd13);
    stepCycle();

    // Back-to-back load responses while the pipeline stalls.
    resp_ready   = 1'b0;
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_tag      = 5'd1;
    stepCycle();
    req_tag = 5'd2;
    stepCycle();
    req_valid       = 1'b0;
    cache_valid_out = 1'b1;
    cache_data_out  = 32'hA1;
    stepCycle();
    cache_data_out = 32'hA2;
    #1;
    checkOutput("t4_cro_drop", 32'(cache_ready_out), 32'd0);
    checkOutput("t4_tag1", 32'(resp_tag), 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("t4_tag1_held", 32'(resp_tag), 32'd1);
    checkOutput("t4_data1_held", resp_data, 32'hA1);
    checkOutput("t4_outstanding_1", 32'(outstanding), 32'd1);
    resp_ready = 1'b1;
    #1;
    checkOutput("t4_cro_back", 32'(cache_ready_out), 32'd1);
    stepCycle();
    cache_valid_out = 1'b0;
    checkOutput("t4_valid_reload", 32'(resp_valid), 32'd1);
    checkOutput("t4_tag2", 32'(resp_tag), 32'd2);
    checkOutput("t4_data2", resp_data, 32'hA2);
    stepCycle();
    checkOutput("t4_drained", 32'(resp_valid), 32'd0);

    // Mixed load/store/load, then wrap-around traffic.
    start = deliveredTags.size();
    applyStimulus(1'b0, 32'h400, 32'h0, 5'd4);
    applyStimulus(1'b1, 32'h404, 32'hCAFE, 5'd9);
    applyStimulus(1'b0, 32'h408, 32'h0, 5'd6);
    cacheRespond(32'h44);
    checkOutput("t5_tag4", 32'(resp_tag), 32'd4);
    checkOutput("t5_data44", resp_data, 32'h44);
    cacheRespond(32'h99);
    cacheRespond(32'h66);
    checkOutput("t5_tag6", 32'(resp_tag), 32'd6);
    checkOutput("t5_data66", resp_data, 32'h66);
    stepCycle();
    checkOutput("t5_model_two_loads", 32'(deliveredTags.size() - start), 32'd2);
    if (deliveredTags.size() - start >= 2) begin
      checkOutput("t5_model_first_tag", 32'(deliveredTags[start]), 32'd4);
      checkOutput("t5_model_second_tag", 32'(deliveredTags[start + 1]), 32'd6);
    end
    for (int i = 0; i < 10; i++) begin
      req_valid       = (i % 3 != 2);
      req_is_store    = 1'(i % 2);
      req_tag         = 5'(i + 8);
      req_addr        = 32'h500 + 32'(4 * i);
      req_wdata       = 32'(i);
      cache_ready_in  = (i != 4);
      cache_valid_out = (pend.size() > 0) && (i % 4 != 0);
      cache_data_out  = 32'h2000 + 32'(i);
      stepCycle();
    end
    req_valid       = 1'b0;
    cache_valid_out = 1'b0;
    cache_ready_in  = 1'b1;
    for (int k = 0; k < 20 && pend.size() > 0; k++) cacheRespond(32'h3000 + 32'(k));
    stepCycle();
    stepCycle();
    checkOutput("t5_no_err", 32'(err), 32'd0);
    checkOutput("t5_drained", 32'(outstanding), 32'd0);

    // Spurious response sets the sticky error.
    cache_valid_out = 1'b1;
    cache_data_out  = 32'hBAD0;
    stepCycle();
    cache_valid_out = 1'b0;
    checkOutput("t6_err_set", 32'(err), 32'd1);
    repeat (3) stepCycle();
    checkOutput("t6_err_held", 32'(err), 32'd1);
    checkOutput("t6_no_state_change", 32'(outstanding), 32'd0);

    // Asynchronous reset with two loads in flight and a pending result.
    resp_ready   = 1'b0;
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_tag = 5'(7 + i);
      stepCycle();
    end
    req_valid = 1'b0;
    cacheRespond(32'h77);
    checkOutput("t6_pre_rst_outstanding", 32'(outstanding), 32'd2);
    checkOutput("t6_pre_rst_valid", 32'(resp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_outstanding", 32'(outstanding), 32'd0);
    checkOutput("t6_async_err", 32'(err), 32'd0);
    checkOutput("t6_async_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("t6_rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("t6_rst_cro", 32'(cache_ready_out), 32'd0);
    stepCycle();
    rst        = 1'b0;
    resp_ready = 1'b1;
    stepCycle();
    cache_valid_out = 1'b1;
    cache_data_out  = 32'h88;
    stepCycle();
    cache_valid_out = 1'b0;
    checkOutput("t6_stale_resp_err", 32'(err), 32'd1);
    checkOutput("t6_stale_no_result", 32'(resp_valid), 32'd0);
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
